// File: rtl/bit4_plus_sweeper_pkg.sv
// Shared types and constants for the 4-bit adder exhaustive sweeper.
package bit4_sweep_pkg;

  localparam int OP_W          = 4;
  localparam int NUM_PAIRS     = 256;
  localparam int ERR_W_DEFAULT = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [OP_W:0] golden_sum(input logic [OP_W-1:0] a,
                                               input logic [OP_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/bit4_plus_sweeper_pair_counter.sv
// Nested opA/opB operand counter with a per-pair hold down-counter.
module bit4_pair_counter
  import bit4_sweep_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            adv,
  output logic [OP_W-1:0] opA,
  output logic [OP_W-1:0] opB,
  output logic            last_pair,
  output logic            sample_now
);

  localparam logic [3:0] HOLD_INIT = 4'(SETTLE - 1);

  logic [3:0] hold;

  assign sample_now = (hold == 4'd0);
  assign last_pair  = (&opA) && (&opB);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opA  <= '0;
      opB  <= '0;
      hold <= '0;
    end else if (clr) begin
      opA  <= '0;
      opB  <= '0;
      hold <= HOLD_INIT;
    end else if (adv) begin
      if (sample_now) begin
        hold <= HOLD_INIT;
        // the final pair stays on the adder inputs once the sweep ends
        if (!last_pair) begin
          opB <= opB + 1'b1;
          if (&opB) opA <= opA + 1'b1;
        end
      end else begin
        hold <= hold - 1'b1;
      end
    end
  end

endmodule

// File: rtl/bit4_plus_sweeper.sv
// Exhaustive in-system checker for a 4-bit adder: sweeps all operand pairs,
// compares {cout,sum} against the golden sum and records errors.
module bit4_plus_sweeper
  import bit4_sweep_pkg::*;
#(
  parameter int SETTLE = 1,
  parameter int ERR_W  = ERR_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [OP_W-1:0]  opA,
  output logic [OP_W-1:0]  opB,
  input  logic [OP_W-1:0]  sum_i,
  input  logic             cout_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             first_err_valid,
  output logic [OP_W-1:0]  first_err_a,
  output logic [OP_W-1:0]  first_err_b
);

  localparam logic [ERR_W-1:0] ERR_MAX = ERR_W'(NUM_PAIRS);

  state_t state, state_nx;
  logic   clr, adv, go, do_cmp;
  logic   last_pair, sample_now, mismatch;

  bit4_pair_counter #(.SETTLE(SETTLE)) u_pair_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .adv        (adv),
    .opA        (opA),
    .opB        (opB),
    .last_pair  (last_pair),
    .sample_now (sample_now)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    clr      = 1'b0;
    adv      = 1'b0;
    go       = 1'b0;
    do_cmp   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx = RUN;
          clr      = 1'b1;
          go       = 1'b1;
        end
      end
      RUN: begin
        // abort suppresses any compare due on the same edge
        if (abort) begin
          state_nx = IDLE;
          clr      = 1'b1;
        end else begin
          adv = 1'b1;
          if (sample_now) begin
            do_cmp = 1'b1;
            if (last_pair) state_nx = DONE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign mismatch = ({cout_i, sum_i} != golden_sum(opA, opB));

  always_ff @(posedge clk) begin
    if (!rst_n || go) begin
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_a     <= '0;
      first_err_b     <= '0;
    end else if (do_cmp && mismatch) begin
      if (err_cnt != ERR_MAX) err_cnt <= err_cnt + 1'b1;
      if (!first_err_valid) begin
        first_err_valid <= 1'b1;
        first_err_a     <= opA;
        first_err_b     <= opB;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign pass = done && (err_cnt == '0);

endmodule

// File: tb/tb_bit4_plus_sweeper.sv
// Bench for bit4_plus_sweeper: SETTLE=1 and SETTLE=3 instances driving faultable adder stubs.
module tb_bit4_plus_sweeper;
  import bit4_sweep_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_s [2];
  logic       abort_s [2];
  int         fault   [2];
  logic [3:0] opa_w   [2];
  logic [3:0] opb_w   [2];
  logic [3:0] sum_w   [2];
  logic       cout_w  [2];
  logic       busy_w  [2];
  logic       done_w  [2];
  logic       pass_w  [2];
  logic [8:0] err_w   [2];
  logic       fev_w   [2];
  logic [3:0] fa_w    [2];
  logic [3:0] fb_w    [2];

  // fault 1: carry stuck at 0, fault 2: sum bit0 stuck at 0
  function automatic logic [4:0] stub_add(input logic [3:0] a, input logic [3:0] b, input int f);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (f == 1) s[4] = 1'b0;
    if (f == 2) s[0] = 1'b0;
    return s;
  endfunction

  assign {cout_w[0], sum_w[0]} = stub_add(opa_w[0], opb_w[0], fault[0]);
  assign {cout_w[1], sum_w[1]} = stub_add(opa_w[1], opb_w[1], fault[1]);

  bit4_plus_sweeper #(.SETTLE(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .abort(abort_s[0]),
    .opA(opa_w[0]), .opB(opb_w[0]), .sum_i(sum_w[0]), .cout_i(cout_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .err_cnt(err_w[0]),
    .first_err_valid(fev_w[0]), .first_err_a(fa_w[0]), .first_err_b(fb_w[0])
  );

  bit4_plus_sweeper #(.SETTLE(3)) dut_s3 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .abort(abort_s[1]),
    .opA(opa_w[1]), .opB(opb_w[1]), .sum_i(sum_w[1]), .cout_i(cout_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .err_cnt(err_w[1]),
    .first_err_valid(fev_w[1]), .first_err_a(fa_w[1]), .first_err_b(fb_w[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input int sel, input string tag);
    chk({tag, " opA"},     int'(opa_w[sel]),  0);
    chk({tag, " opB"},     int'(opb_w[sel]),  0);
    chk({tag, " busy"},    int'(busy_w[sel]), 0);
    chk({tag, " done"},    int'(done_w[sel]), 0);
    chk({tag, " pass"},    int'(pass_w[sel]), 0);
    chk({tag, " err_cnt"}, int'(err_w[sel]),  0);
    chk({tag, " fev"},     int'(fev_w[sel]),  0);
    chk({tag, " fa"},      int'(fa_w[sel]),   0);
    chk({tag, " fb"},      int'(fb_w[sel]),   0);
  endtask

  typedef struct {
    int sel;        // 0: SETTLE=1, 1: SETTLE=3
    int fault;
    int abort_idx;  // pair index at which abort is asserted, -1 for none
    bit poke;       // pulse start mid-sweep
    int err;
    bit fev;
    int fa;
    int fb;
    bit done;
    bit pass;
    int cycles;
  } vec_t;

  vec_t vecs [7];
  vec_t exp_q [$];

  task automatic run_vec(input vec_t v);
    int   s, k, idx;
    bit   fin, seq_ok;
    vec_t e;
    s      = (v.sel == 0) ? 1 : 3;
    fin    = 1'b0;
    seq_ok = 1'b1;
    k      = 0;
    fault[v.sel] = v.fault;
    exp_q.push_back(v);
    @(negedge clk) start_s[v.sel] = 1'b1;
    @(negedge clk) start_s[v.sel] = 1'b0;
    chk("busy after start", int'(busy_w[v.sel]), 1);
    while (!fin && k < 2000) begin
      if (done_w[v.sel]) begin
        fin = 1'b1;
        chk("done latency", k, v.cycles);
        chk("final opA", int'(opa_w[v.sel]), 15);
        chk("final opB", int'(opb_w[v.sel]), 15);
      end else begin
        idx = k / s;
        if (int'({opa_w[v.sel], opb_w[v.sel]}) != idx) seq_ok = 1'b0;
        start_s[v.sel] = v.poke && (k == 50);
        if (v.abort_idx >= 0 && k == v.abort_idx * s) begin
          abort_s[v.sel] = 1'b1;
          @(negedge clk) abort_s[v.sel] = 1'b0;
          chk("abort busy", int'(busy_w[v.sel]), 0);
          chk("abort opA",  int'(opa_w[v.sel]),  0);
          chk("abort opB",  int'(opb_w[v.sel]),  0);
          fin = 1'b1;
        end else begin
          @(negedge clk);
          k++;
        end
      end
    end
    chk("sweep ended", int'(fin), 1);
    chk("operand sequence", int'(seq_ok), 1);
    e = exp_q.pop_front();
    chk("err_cnt",         int'(err_w[v.sel]),  e.err);
    chk("first_err_valid", int'(fev_w[v.sel]),  int'(e.fev));
    chk("first_err_a",     int'(fa_w[v.sel]),   e.fa);
    chk("first_err_b",     int'(fb_w[v.sel]),   e.fb);
    chk("done",            int'(done_w[v.sel]), int'(e.done));
    chk("pass",            int'(pass_w[v.sel]), int'(e.pass));
    chk("busy at end",     int'(busy_w[v.sel]), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    vecs[0] = '{0, 0,  -1, 1'b0,   0, 1'b0, 0,  0, 1'b1, 1'b1, 256};
    vecs[1] = '{0, 1,  -1, 1'b0, 120, 1'b1, 1, 15, 1'b1, 1'b0, 256};
    vecs[2] = '{0, 2,  -1, 1'b1, 128, 1'b1, 0,  1, 1'b1, 1'b0, 256};
    vecs[3] = '{1, 0,  -1, 1'b0,   0, 1'b0, 0,  0, 1'b1, 1'b1, 768};
    vecs[4] = '{0, 1, 100, 1'b0,  15, 1'b1, 1, 15, 1'b0, 1'b0,  -1};
    vecs[5] = '{0, 0,  -1, 1'b0,   0, 1'b0, 0,  0, 1'b1, 1'b1, 256};
    vecs[6] = '{1, 2,  -1, 1'b0, 128, 1'b1, 0,  1, 1'b1, 1'b0, 768};

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0;
      abort_s[i] = 1'b0;
      fault[i]   = 0;
    end
    repeat (3) @(negedge clk);
    chk_all_zero(0, "reset s1");
    chk_all_zero(1, "reset s3");
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // reset mid-sweep at pair (9,9), with start and abort also high
    fault[0] = 1;
    @(negedge clk) start_s[0] = 1'b1;
    @(negedge clk) start_s[0] = 1'b0;
    k = 0;
    while (!(opa_w[0] == 4'd9 && opb_w[0] == 4'd9) && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("reached pair 9,9", k, 9 * 16 + 9);
    rst_n      = 1'b0;
    start_s[0] = 1'b1;
    abort_s[0] = 1'b1;
    @(negedge clk);
    chk_all_zero(0, "midsweep reset");
    rst_n      = 1'b1;
    start_s[0] = 1'b0;
    abort_s[0] = 1'b0;
    @(negedge clk);

    // start and abort together in IDLE: start wins
    start_s[0] = 1'b1;
    abort_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    abort_s[0] = 1'b0;
    chk("start over abort busy", int'(busy_w[0]), 1);
    chk("start over abort opB",  int'(opb_w[0]),  0);
    @(negedge clk);
    chk("run advance opB", int'(opb_w[0]), 1);
    abort_s[0] = 1'b1;
    @(negedge clk);
    abort_s[0] = 1'b0;
    chk("final abort busy", int'(busy_w[0]), 0);
    chk("final abort done", int'(done_w[0]), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
